// File: rtl/cache_cfg_pkg.sv
// Shared L1 cache configuration: default geometry, byte-enable width
// derivation and the INIT/READY state encoding used by the data and tag arrays.
package cache_cfg_pkg;

  localparam int DEF_ADDR_WIDTH = 13;
  localparam int DEF_DATA_W     = 256;
  localparam int DEF_WAYS       = 4;

  // Array bring-up FSM encoding.
  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // One byte enable per 8 data bits.
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/dsram_way.sv
// Single way of the L1 data array: byte-enabled write port plus a read
// capture register. WR_MODE picks what a same-cycle read of the written index
// returns: 0 = stored (old) line, 1 = line merged with the write bytes.
module dsram_way
  import cache_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int BE_W       = be_width(DATA_W),
  parameter int WR_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic                  we,
  input  logic [BE_W-1:0]       be,
  input  logic [DATA_W-1:0]     wd,
  input  logic                  re,
  output logic [DATA_W-1:0]     rd
);

  localparam int ENTRIES = 2 ** ADDR_WIDTH;

  logic [DATA_W-1:0] mem [ENTRIES];
  logic [DATA_W-1:0] stored;
  logic [DATA_W-1:0] merged;

  assign stored = mem[a];

  // Stored line with this cycle's write bytes overlaid (write-through view).
  always_comb begin
    // NOTE: blocking assignments here, with the default first so every path assigns and no latch is inferred.
    merged = stored;
    for (int i = 0; i < BE_W; i++) begin
      if (we && be[i]) merged[8*i +: 8] = wd[8*i +: 8];
    end
  end

  // Byte-enabled write into the array.
  // NOTE: the array itself has no reset; the zeroing sweep clears it, which keeps it mappable onto SRAM macros.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[a][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // Read capture; holds its last value when no read is issued.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (reset)   rd <= '0;
    else if (re) rd <= (WR_MODE == 1) ? merged : stored;
  end

endmodule

// File: rtl/dsram_nway.sv
// N-way L1 data array. After reset a sweep writes zero to every index of every
// way, then the array serves per-way byte-enabled writes and all-way reads.
// OUT_REG=1 adds a second output stage for a 2-cycle load/use path.
module dsram_nway
  import cache_cfg_pkg::*;
#(
  parameter int  ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int  DATA_W     = DEF_DATA_W,
  parameter int  WAYS       = DEF_WAYS,
  parameter int  WR_MODE    = 0,
  parameter int  OUT_REG    = 0,
  localparam int BE_W       = be_width(DATA_W)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  a,
  input  logic [WAYS-1:0]        way_sel,
  input  logic [BE_W-1:0]        be,
  input  logic [DATA_W-1:0]      wd,
  input  logic                   write,
  input  logic                   read,
  output logic [WAYS*DATA_W-1:0] rd,
  output logic                   rd_valid,
  output logic                   init_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  logic [0:0]             state;
  logic [ADDR_WIDTH-1:0]  sweep_cnt;
  logic                   sweeping;

  logic [ADDR_WIDTH-1:0]  arr_a;
  logic [BE_W-1:0]        arr_be;
  logic [DATA_W-1:0]      arr_wd;
  logic [WAYS-1:0]        arr_we;
  logic                   rd_en;

  logic [WAYS*DATA_W-1:0] rd_way;
  logic                   rd_v1;

  assign sweeping  = (state == ST_INIT);
  assign init_done = (state == ST_READY);

  // Zeroing sweep: one index per cycle, then park in READY until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (sweep_cnt == LAST_IDX) state     <= ST_READY;
      else                       sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  // The sweep owns the array port until it finishes; requests are dropped.
  assign arr_a  = sweeping ? sweep_cnt : a;
  assign arr_be = sweeping ? '1 : be;
  assign arr_wd = sweeping ? '0 : wd;
  assign arr_we = sweeping ? {WAYS{~reset}} : (way_sel & {WAYS{write & ~reset}});
  assign rd_en  = ~sweeping & read & ~reset;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dsram_way #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_W     (DATA_W),
      .BE_W       (BE_W),
      .WR_MODE    (WR_MODE)
    ) u_way (
      .clk   (clk),
      .reset (reset),
      .a     (arr_a),
      .we    (arr_we[w]),
      .be    (arr_be),
      .wd    (arr_wd),
      .re    (rd_en),
      .rd    (rd_way[w*DATA_W +: DATA_W])
    );
  end

  // First-stage valid, aligned with the way read registers.
  always_ff @(posedge clk) begin
    if (reset) rd_v1 <= 1'b0;
    else       rd_v1 <= rd_en;
  end

  if (OUT_REG == 1) begin : g_out_reg
    logic [WAYS*DATA_W-1:0] rd_q;
    logic                   rd_v2;

    // Second output stage; data only moves when the first stage is valid.
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_q  <= '0;
        rd_v2 <= 1'b0;
      end else begin
        rd_v2 <= rd_v1;
        if (rd_v1) rd_q <= rd_way;
      end
    end

    assign rd       = rd_q;
    assign rd_valid = rd_v2;
  end else begin : g_no_out_reg
    assign rd       = rd_way;
    assign rd_valid = rd_v1;
  end

endmodule

// File: tb/tb_dsram_nway.sv
// Directed bench for dsram_nway. Two instances share one stimulus stream:
// dut_a is read-first with a 1-cycle output, dut_b is write-through with the
// extra output register, so dut_b results appear one cycle after dut_a's.
module tb_dsram_nway;

  localparam int AW      = 4;
  localparam int DW      = 256;
  localparam int WAYS    = 4;
  localparam int BE_W    = DW / 8;
  localparam int ENTRIES = 2 ** AW;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [AW-1:0]        a;
  logic [WAYS-1:0]      way_sel;
  logic [BE_W-1:0]      be;
  logic [DW-1:0]        wd;
  logic                 write;
  logic                 read;

  logic [WAYS*DW-1:0]   rd_a, rd_b;
  logic                 rv_a, rv_b;
  logic                 id_a, id_b;

  logic [WAYS*DW-1:0]   r0, r1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dsram_nway #(.ADDR_WIDTH(AW), .DATA_W(DW), .WAYS(WAYS), .WR_MODE(0), .OUT_REG(0)) dut_a (
    .clk(clk), .reset(reset), .a(a), .way_sel(way_sel), .be(be), .wd(wd),
    .write(write), .read(read), .rd(rd_a), .rd_valid(rv_a), .init_done(id_a)
  );

  dsram_nway #(.ADDR_WIDTH(AW), .DATA_W(DW), .WAYS(WAYS), .WR_MODE(1), .OUT_REG(1)) dut_b (
    .clk(clk), .reset(reset), .a(a), .way_sel(way_sel), .be(be), .wd(wd),
    .write(write), .read(read), .rd(rd_b), .rd_valid(rv_b), .init_done(id_b)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_ways(input string tag, input logic [WAYS*DW-1:0] obs,
                            input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                            input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    check({tag, "_w0"}, obs[0*DW +: DW], e0);
    check({tag, "_w1"}, obs[1*DW +: DW], e1);
    check({tag, "_w2"}, obs[2*DW +: DW], e2);
    check({tag, "_w3"}, obs[3*DW +: DW], e3);
  endtask

  task automatic idle();
    way_sel = '0;
    be      = '0;
    wd      = '0;
    write   = 1'b0;
    read    = 1'b0;
  endtask

  // One write cycle, then idle.
  task automatic wr(input logic [AW-1:0] addr, input logic [WAYS-1:0] ws,
                    input logic [BE_W-1:0] b, input logic [DW-1:0] d);
    a = addr; way_sel = ws; be = b; wd = d; write = 1'b1; read = 1'b0;
    @(negedge clk);
    idle();
  endtask

  // One read cycle; returns dut_a data after 1 cycle and dut_b data after 2.
  task automatic rd_req(input string tag, input logic [AW-1:0] addr,
                        output logic [WAYS*DW-1:0] out_a, output logic [WAYS*DW-1:0] out_b);
    a = addr; read = 1'b1; write = 1'b0;
    @(negedge clk);
    idle();
    check_bit({tag, "_rv_a"}, rv_a, 1'b1);
    check_bit({tag, "_rv_b_early"}, rv_b, 1'b0);
    out_a = rd_a;
    @(negedge clk);
    check_bit({tag, "_rv_a_drop"}, rv_a, 1'b0);
    check_bit({tag, "_rv_b"}, rv_b, 1'b1);
    out_b = rd_b;
  endtask

  // Wait out a full sweep, checking init_done rises on exactly the ENTRIES-th cycle.
  task automatic sweep_wait(input string tag);
    for (int k = 1; k <= ENTRIES; k++) begin
      @(negedge clk);
      check_bit($sformatf("%s_id_a_%0d", tag, k), id_a, k == ENTRIES);
      check_bit($sformatf("%s_id_b_%0d", tag, k), id_b, k == ENTRIES);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    a = '0;
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state.
    check_ways("rst_rd_a", rd_a, '0, '0, '0, '0);
    check_ways("rst_rd_b", rd_b, '0, '0, '0, '0);
    check_bit("rst_rv_a", rv_a, 1'b0);
    check_bit("rst_rv_b", rv_b, 1'b0);
    check_bit("rst_id_a", id_a, 1'b0);
    check_bit("rst_id_b", id_b, 1'b0);

    // Sweep; a write+read to already-swept index 2 during it must be ignored.
    reset = 1'b0;
    for (int k = 1; k <= ENTRIES; k++) begin
      if (k == 11) begin
        a = 4'd2; way_sel = '1; be = '1; wd = '1; write = 1'b1; read = 1'b1;
      end
      @(negedge clk);
      idle();
      check_bit($sformatf("init_id_a_%0d", k), id_a, k == ENTRIES);
      check_bit($sformatf("init_id_b_%0d", k), id_b, k == ENTRIES);
      check_bit($sformatf("init_rv_a_%0d", k), rv_a, 1'b0);
      check_bit($sformatf("init_rv_b_%0d", k), rv_b, 1'b0);
    end

    // Every index of every way reads zero (index 2 included).
    for (int i = 0; i < ENTRIES; i++) begin
      rd_req($sformatf("zero_%0d", i), AW'(i), r0, r1);
      check_ways($sformatf("zero_a_%0d", i), r0, '0, '0, '0, '0);
      check_ways($sformatf("zero_b_%0d", i), r1, '0, '0, '0, '0);
    end

    // Single-way low-word write, read back-to-back; upper wd bytes must not land.
    wr(4'd5, 4'b0010, 32'h0000_000F, {8{32'hDEAD_BEEF}});
    rd_req("w5", 4'd5, r0, r1);
    check_ways("w5_a", r0, '0, 256'hDEAD_BEEF, '0, '0);
    check_ways("w5_b", r1, '0, 256'hDEAD_BEEF, '0, '0);

    // Multi-hot ways, middle bytes; then two no-op writes (no way, no bytes).
    wr(4'd5, 4'b1001, 32'h0000_0F00, {32{8'hA5}});
    wr(4'd5, 4'b0000, '1, '1);
    wr(4'd5, 4'b1111, '0, '1);
    rd_req("w5m", 4'd5, r0, r1);
    check_ways("w5m_a", r0, 256'hA5A5A5A5_00000000_00000000, 256'hDEAD_BEEF,
               '0, 256'hA5A5A5A5_00000000_00000000);
    check_ways("w5m_b", r1, 256'hA5A5A5A5_00000000_00000000, 256'hDEAD_BEEF,
               '0, 256'hA5A5A5A5_00000000_00000000);

    // Collision at index 3: read-first vs byte-merged write-through.
    wr(4'd3, 4'b0001, 32'h0000_000F, {8{32'h1111_1111}});
    a = 4'd3; way_sel = 4'b0001; be = 32'h0000_000F; wd = {8{32'h2222_2222}};
    write = 1'b1; read = 1'b1;
    @(negedge clk);
    idle();
    check_bit("col_rv_a", rv_a, 1'b1);
    check_ways("col_a", rd_a, 256'h1111_1111, '0, '0, '0);
    @(negedge clk);
    check_bit("col_rv_b", rv_b, 1'b1);
    check_ways("col_b", rd_b, 256'h2222_2222, '0, '0, '0);
    rd_req("col_after", 4'd3, r0, r1);
    check_ways("col_after_a", r0, 256'h2222_2222, '0, '0, '0);
    check_ways("col_after_b", r1, 256'h2222_2222, '0, '0, '0);

    // Back-to-back reads of 0,1,2 through both pipelines.
    wr(4'd0, 4'b0100, 32'h1, {32{8'hA0}});
    wr(4'd1, 4'b0100, 32'h1, {32{8'hA1}});
    wr(4'd2, 4'b0100, 32'h1, {32{8'hA2}});
    a = 4'd0; read = 1'b1;
    @(negedge clk);
    check_bit("pipe1_rv_a", rv_a, 1'b1);
    check("pipe1_rd_a", rd_a[2*DW +: DW], 256'hA0);
    check_bit("pipe1_rv_b", rv_b, 1'b0);
    a = 4'd1;
    @(negedge clk);
    check_bit("pipe2_rv_a", rv_a, 1'b1);
    check("pipe2_rd_a", rd_a[2*DW +: DW], 256'hA1);
    check_bit("pipe2_rv_b", rv_b, 1'b1);
    check("pipe2_rd_b", rd_b[2*DW +: DW], 256'hA0);
    a = 4'd2;
    @(negedge clk);
    check_bit("pipe3_rv_a", rv_a, 1'b1);
    check("pipe3_rd_a", rd_a[2*DW +: DW], 256'hA2);
    check_bit("pipe3_rv_b", rv_b, 1'b1);
    check("pipe3_rd_b", rd_b[2*DW +: DW], 256'hA1);
    idle();
    @(negedge clk);
    check_bit("pipe4_rv_a", rv_a, 1'b0);
    check("pipe4_hold_a", rd_a[2*DW +: DW], 256'hA2);
    check_bit("pipe4_rv_b", rv_b, 1'b1);
    check("pipe4_rd_b", rd_b[2*DW +: DW], 256'hA2);
    @(negedge clk);
    check_bit("pipe5_rv_b", rv_b, 1'b0);
    check("pipe5_hold_b", rd_b[2*DW +: DW], 256'hA2);

    // Reset mid-read flushes both pipelines.
    a = 4'd5; read = 1'b1;
    @(negedge clk);
    idle();
    check_bit("flush_pre_rv_a", rv_a, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_bit("flush_rv_a", rv_a, 1'b0);
    check_bit("flush_rv_b", rv_b, 1'b0);
    check_bit("flush_id_a", id_a, 1'b0);
    check_ways("flush_rd_a", rd_a, '0, '0, '0, '0);
    check_ways("flush_rd_b", rd_b, '0, '0, '0, '0);

    // Reset again at sweep count 7; a full sweep must follow.
    repeat (7) @(negedge clk);
    check_bit("mid_id_a", id_a, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sweep_wait("resweep");

    // Previously written indices are zero again.
    rd_req("post5", 4'd5, r0, r1);
    check_ways("post5_a", r0, '0, '0, '0, '0);
    check_ways("post5_b", r1, '0, '0, '0, '0);
    rd_req("post3", 4'd3, r0, r1);
    check_ways("post3_a", r0, '0, '0, '0, '0);
    check_ways("post3_b", r1, '0, '0, '0, '0);
    rd_req("post0", 4'd0, r0, r1);
    check_ways("post0_a", r0, '0, '0, '0, '0);
    check_ways("post0_b", r1, '0, '0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
